// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Two one-entry writeback slots feed a single register-file write port.
package regfile_pkg;

    localparam int REG_COUNT = 32;
    localparam int ZERO_REG  = 31;
    localparam int DATA_W    = 64;
    localparam int REG_W     = $clog2(REG_COUNT);
    localparam int AGE_W     = 2;

    // The destination field cannot be called "reg", which is a keyword.
    typedef struct packed {
        logic [REG_W-1:0]  reg_addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } grant_e;

    function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [REG_W-1:0] r);
        logic [REG_COUNT-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    function automatic logic is_zero_reg(input logic [REG_W-1:0] r);
        return r == REG_W'(ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_wb_slot.sv
// One-entry writeback buffer holding a request plus how many cycles it has waited.
// Writes aimed at the zero register are accepted but never stored.
module wb_slot
    import regfile_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push_valid,
    input  wb_req_t          i_push,
    input  logic             i_grant,
    output logic             o_ready,
    output logic             o_valid,
    output wb_req_t          o_req,
    output logic [AGE_W-1:0] o_age,
    output logic [REG_COUNT-1:0] o_pending
);

    logic             r_valid;
    wb_req_t          r_req;
    logic [AGE_W-1:0] r_age;
    logic             w_accept;
    logic             w_load;

    assign o_ready  = !r_valid || i_grant;
    assign w_accept = i_push_valid && o_ready;
    assign w_load   = w_accept && !is_zero_reg(i_push.reg_addr);

    // Age saturates; it only matters when both slots target the same register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_req   <= '0;
            r_age   <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_req   <= i_push;
            r_age   <= '0;
        end else if (i_grant) begin
            r_valid <= 1'b0;
            r_age   <= '0;
        end else if (r_valid && r_age != '1) begin
            r_age   <= r_age + AGE_W'(1);
        end
    end

    assign o_valid   = r_valid;
    assign o_req     = r_req;
    assign o_age     = r_age;
    assign o_pending = r_valid ? reg_onehot(r_req.reg_addr) : '0;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU (A) and load (B) writebacks onto one register-file write port:
// round-robin between slots, with same-register writes kept in program order.
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [REG_W-1:0]     a_reg,
    input  logic [DATA_W-1:0]    a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [REG_W-1:0]     b_reg,
    input  logic [DATA_W-1:0]    b_data,
    output logic                 regWrite,
    output logic [REG_W-1:0]     writeRegister,
    output logic [DATA_W-1:0]    writeData,
    output logic [REG_COUNT-1:0] pending
);

    localparam int N_SLOTS = 2;
    localparam int SLOT_A  = 0;
    localparam int SLOT_B  = 1;

    logic                 w_push_valid [N_SLOTS];
    wb_req_t              w_push       [N_SLOTS];
    logic                 w_slot_grant [N_SLOTS];
    logic                 w_ready      [N_SLOTS];
    logic                 w_valid      [N_SLOTS];
    wb_req_t              w_req        [N_SLOTS];
    logic [AGE_W-1:0]     w_age        [N_SLOTS];
    logic [REG_COUNT-1:0] w_pending    [N_SLOTS];

    grant_e               w_grant;
    wb_req_t              w_sel;
    logic [REG_COUNT-1:0] w_pending_or;

    logic                 r_favour_b;
    logic                 r_reg_write;
    logic [REG_W-1:0]     r_write_reg;
    logic [DATA_W-1:0]    r_write_data;

    assign w_push_valid[SLOT_A] = a_valid;
    assign w_push_valid[SLOT_B] = b_valid;
    assign w_push[SLOT_A]       = '{reg_addr: a_reg, data: a_data};
    assign w_push[SLOT_B]       = '{reg_addr: b_reg, data: b_data};
    assign w_slot_grant[SLOT_A] = (w_grant == GNT_A);
    assign w_slot_grant[SLOT_B] = (w_grant == GNT_B);

    generate
        for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
            wb_slot u_slot (
                .clk          (clk),
                .reset_n      (reset_n),
                .i_push_valid (w_push_valid[gi]),
                .i_push       (w_push[gi]),
                .i_grant      (w_slot_grant[gi]),
                .o_ready      (w_ready[gi]),
                .o_valid      (w_valid[gi]),
                .o_req        (w_req[gi]),
                .o_age        (w_age[gi]),
                .o_pending    (w_pending[gi])
            );
        end
    endgenerate

    // Same destination: the older write goes first; a tie means both loaded on
    // one edge, and B goes first so that A's value is the one left in the file.
    always_comb begin
        w_grant = GNT_NONE;
        if (w_valid[SLOT_A] && w_valid[SLOT_B]) begin
            if (w_req[SLOT_A].reg_addr == w_req[SLOT_B].reg_addr) begin
                w_grant = (w_age[SLOT_A] > w_age[SLOT_B]) ? GNT_A : GNT_B;
            end else begin
                w_grant = r_favour_b ? GNT_B : GNT_A;
            end
        end else if (w_valid[SLOT_A]) begin
            w_grant = GNT_A;
        end else if (w_valid[SLOT_B]) begin
            w_grant = GNT_B;
        end
    end

    assign w_sel = (w_grant == GNT_B) ? w_req[SLOT_B] : w_req[SLOT_A];

    always_comb begin
        w_pending_or = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_pending_or = w_pending_or | w_pending[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_favour_b   <= 1'b0;
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else begin
            r_reg_write <= (w_grant != GNT_NONE);
            if (w_grant != GNT_NONE) begin
                r_write_reg  <= w_sel.reg_addr;
                r_write_data <= w_sel.data;
                r_favour_b   <= (w_grant == GNT_A);
            end
        end
    end

    assign a_ready       = w_ready[SLOT_A];
    assign b_ready       = w_ready[SLOT_B];
    assign regWrite      = r_reg_write;
    assign writeRegister = r_write_reg;
    assign writeData     = r_write_data;
    assign pending       = w_pending_or;

endmodule
